// File: rtl/fizzbuzz_gen.sv
// FizzBuzz byte source for a UART transmitter: emits lines for 1..MAX_N, each ending in CR LF,
// one byte per strobe, paced by the transmitter's busy flag.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for i_start; counters parked at n=1
// SEND      | present current byte, one-cycle o_tx_valid
// WAIT_ACK  | wait for the TX stage to raise its busy flag
// WAIT_DONE | wait for the TX stage to finish, then next char or line
// NEXT      | line complete: finish the run or advance n
module fizzbuzz_gen #(
    parameter int MAX_N = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_tx_busy,
    output logic [7:0] o_tx_data,
    output logic       o_tx_valid,
    output logic       o_busy,
    output logic       o_done
);
    localparam int DIGITS = (MAX_N >= 1000) ? 4 : (MAX_N >= 100) ? 3 : (MAX_N >= 10) ? 2 : 1;
    localparam int BW = 4 * DIGITS;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          t;
        r = '0;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    localparam logic [15:0]   MAX_BCD_FULL = to_bcd(MAX_N);
    localparam logic [BW-1:0] MAX_BCD      = MAX_BCD_FULL[BW-1:0];

    function automatic logic [7:0] word_ch(input logic is_buzz, input logic [1:0] k);
        case (k)
            2'd0:    word_ch = is_buzz ? 8'h42 : 8'h46;
            2'd1:    word_ch = is_buzz ? 8'h75 : 8'h69;
            default: word_ch = 8'h7A;
        endcase
    endfunction

    typedef enum logic [2:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE, NEXT} state_t;

    state_t        state;
    logic [BW-1:0] bcd;
    logic [BW-1:0] bcd_inc;
    logic [1:0]    msd;
    logic [1:0]    msd_inc;
    logic [1:0]    mod3;
    logic [2:0]    mod5;
    logic [3:0]    char_idx;
    logic [3:0]    text_len;
    logic [3:0]    digit;
    logic [7:0]    cur_byte;
    logic          fizz;
    logic          buzz;
    logic          last_char;

    assign fizz      = (mod3 == 2'd0);
    assign buzz      = (mod5 == 3'd0);
    assign last_char = (char_idx == text_len + 4'd1);

    always_comb begin
        if (fizz && buzz)
            text_len = 4'd8;
        else if (fizz || buzz)
            text_len = 4'd4;
        else
            text_len = {2'b00, msd} + 4'd1;
    end

    // Numbers are sent MSD first, so character k maps to digit msd-k.
    always_comb begin
        digit = '0;
        for (int i = 0; i < DIGITS; i++)
            if (4'(i) == ({2'b00, msd} - char_idx))
                digit = bcd[4*i +: 4];
        if (char_idx == text_len)
            cur_byte = 8'h0D;
        else if (char_idx == text_len + 4'd1)
            cur_byte = 8'h0A;
        else if (fizz && !(buzz && char_idx >= 4'd4))
            cur_byte = word_ch(1'b0, char_idx[1:0]);
        else if (buzz)
            cur_byte = word_ch(1'b1, char_idx[1:0]);
        else
            cur_byte = {4'h3, digit};
    end

    always_comb begin
        logic carry;
        carry   = 1'b1;
        bcd_inc = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (bcd[4*i +: 4] == 4'd9) begin
                    bcd_inc[4*i +: 4] = 4'd0;
                end else begin
                    bcd_inc[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        msd_inc = msd;
        for (int i = 0; i < DIGITS; i++)
            if (bcd_inc[4*i +: 4] != 4'd0)
                msd_inc = 2'(i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bcd        <= BW'(1);
            msd        <= '0;
            mod3       <= 2'd1;
            mod5       <= 3'd1;
            char_idx   <= '0;
            o_tx_data  <= '0;
            o_tx_valid <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_tx_valid <= 1'b0;
            o_done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        o_busy   <= 1'b1;
                        char_idx <= '0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    o_tx_data  <= cur_byte;
                    o_tx_valid <= 1'b1;
                    state      <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (i_tx_busy)
                        state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!i_tx_busy) begin
                        if (last_char) begin
                            state <= NEXT;
                        end else begin
                            char_idx <= char_idx + 4'd1;
                            state    <= SEND;
                        end
                    end
                end
                NEXT: begin
                    char_idx <= '0;
                    if (bcd == MAX_BCD) begin
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                        bcd    <= BW'(1);
                        msd    <= '0;
                        mod3   <= 2'd1;
                        mod5   <= 3'd1;
                        state  <= IDLE;
                    end else begin
                        bcd   <= bcd_inc;
                        msd   <= msd_inc;
                        mod3  <= (mod3 == 2'd2) ? 2'd0 : mod3 + 2'd1;
                        mod5  <= (mod5 == 3'd4) ? 3'd0 : mod5 + 3'd1;
                        state <= SEND;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/fizzbuzz_gen.md
# fizzbuzz_gen

Byte-stream source that drives the UART transmitter with the FizzBuzz sequence for 1..MAX_N, one ASCII line per number, each line terminated by CR LF. It sits directly upstream of the UART TX stage. It presents one byte at a time on `o_tx_data` with a one-cycle `o_tx_valid` pulse, and it paces itself from that stage's busy flag. A run starts on `i_start` and ends with a one-cycle `o_done`.

## Interface
- `MAX_N`, default 100: last number emitted; legal range 1..9999.
- `DIGITS`, derived localparam (not overridable): decimal digit count of `MAX_N`; BCD counter width is 4*`DIGITS`.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset; one clock domain.
- `i_start`  in  1  run request; sampled only in IDLE.
- `i_tx_busy`  in  1  TX stage busy flag; rises the cycle after it accepts a byte and stays high until the stop bit ends.
- `o_tx_data`  out  8  ASCII byte to send; registered.
- `o_tx_valid`  out  1  one-cycle strobe: `o_tx_data` is valid; registered.
- `o_busy`  out  1  high from the start acceptance until `o_done`.
- `o_done`  out  1  one-cycle pulse after the final LF is fully transmitted.

## Operation
- Reset values: `o_tx_data`=0x00, `o_tx_valid`=0, `o_busy`=0, `o_done`=0. Internally: number BCD=1, mod-3 counter=1, mod-5 counter=1, state IDLE.
- Per-number line content:
  - n%3==0 and n%5==0: "FizzBuzz".
  - n%3==0 only: "Fizz".
  - n%5==0 only: "Buzz".
  - Otherwise: decimal n, no leading zeros, MSD first, digits as 0x30+d.
  - Every line is followed by 0x0D, 0x0A.
- Divisibility comes from wrap counters: mod-3 runs 0..2 and mod-5 runs 0..4. Both advance with n. No divider is used.
- The number is a `DIGITS`-digit BCD counter with ripple carry: 9→0 carries into the next digit, e.g. 99→100. The first non-zero digit index is tracked for suppressing leading zeros.
- States:
  - IDLE: `o_busy`=0. On `i_start`=1, go to SEND.
  - SEND: drive the current byte, assert `o_tx_valid` for one cycle, go to WAIT_ACK.
  - WAIT_ACK: hold until `i_tx_busy`=1, then go to WAIT_DONE.
  - WAIT_DONE: hold until `i_tx_busy`=0.
    - If more bytes remain in the line, advance the character index and go to SEND.
    - After the LF, go to NEXT.
  - NEXT:
    - If n==`MAX_N`: pulse `o_done`, go to IDLE, and reset n and the counters to 1.
    - Otherwise: increment n and the counters, clear the character index, go to SEND.
- `o_tx_valid` is never asserted while `i_tx_busy`=1 and never for two consecutive cycles.
- `i_start` outside IDLE is ignored; the run in progress is not restarted.
- `o_tx_data` holds its last value between strobes.
- Reset mid-run: the block enters IDLE immediately and asynchronously, `o_tx_valid` drops at once, and no further bytes are sent. The partial line is abandoned and the next run starts at 1.

## Timing
- If `i_start` is sampled high at edge k in IDLE, `o_busy`=1 after edge k, and `o_tx_valid`=1 during the cycle between edges k+1 and k+2.
- Inter-byte gap: if `i_tx_busy` is sampled low in WAIT_DONE at edge e, the next `o_tx_valid` is high in the cycle e+1..e+2. The extra cycle is spent in NEXT when crossing a line.
- WAIT_ACK absorbs the one-cycle lag between acceptance and `i_tx_busy` rising. No byte is lost or duplicated for any TX bit period ≥1.
- `o_done` rises one edge after NEXT detects n==`MAX_N`. `o_busy` falls on the same edge.
- Bytes per run, for `MAX_N`=15: 73.

## Test plan
- `MAX_N`=15, behavioral UART model (10 clk/bit), pulse `i_start` -> exactly 73 bytes: "1\r\n2\r\nFizz\r\n4\r\nBuzz\r\n…14\r\nFizzBuzz\r\n", then one `o_done` pulse.
- `MAX_N`=1 -> bytes 0x31 0x0D 0x0A, `o_done`, `o_busy`=0. Second `i_start` -> identical stream.
- `MAX_N`=101 -> line 100 is "Buzz". Lines 98, 99, 101 are "98", "Fizz", "101", with no leading zeros; 101 is sent as 0x31 0x30 0x31.
- Check: `o_tx_valid` only when `i_tx_busy`=0, one cycle wide; extra `i_start` pulses mid-run ignored; start-to-first-valid latency is 2 edges.
- Assert `rst` during byte 5 of a run -> `o_tx_valid`, `o_busy`, `o_done` are 0 immediately. After release, `i_start` -> stream restarts with "1\r\n".
- Model holds busy low for 3 cycles before rising (slow ack) -> the block waits in WAIT_ACK; no duplicate strobe.
